vpifo_sram_top: RTL and testbench

- Virtualized PIFO (push-in, first-out) priority-queue block: TREE_NUM independent logical queues share one storage engine.
- Each logical queue holds up to CAP = 2^(LEVEL+1)-2 elements, the capacity of an order-2 BMW tree with LEVEL levels.
- LEVEL independent request lanes each carry push/pop/tree_id and buffer requests in a per-lane task FIFO.
- A single engine serves the lane FIFOs round-robin, one operation per cycle.

---
 rtl/vpifo_pkg.sv | 20 ++
 rtl/vpifo_task_fifo.sv | 53 +++++
 rtl/vpifo_sram_top.sv | 190 +++++++++++++++++++
 tb/tb_vpifo_sram_top.sv | 366 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vpifo_pkg.sv
// Shared types and sizing helpers for the virtualized PIFO block.
// Holds the task opcode enum, tree capacity and index-width functions.
package vpifo_pkg;

  typedef enum logic {
    OP_PUSH = 1'b0,
    OP_POP  = 1'b1
  } op_e;

  // Capacity of an order-2 BMW tree with `level` levels.
  function automatic int cap_f(input int level);
    return (2 << level) - 2;
  endfunction

  // Index width for n items, never narrower than one bit.
  function automatic int idw_f(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/vpifo_task_fifo.sv
// Per-lane task FIFO, DEPTH entries (power of two, >= 2) of DW bits.
// Ports: i_wr/i_wdata push, i_rd pop, o_rdata head, o_full/o_empty flags.
module vpifo_task_fifo #(
  parameter int DW    = 8,
  parameter int DEPTH = 4
) (
  input  logic          i_clk,
  input  logic          i_arst_n,
  input  logic          i_wr,
  input  logic [DW-1:0] i_wdata,
  input  logic          i_rd,
  output logic [DW-1:0] o_rdata,
  output logic          o_full,
  output logic          o_empty
);
  localparam int AW = $clog2(DEPTH);

  logic [DW-1:0] r_mem [DEPTH];
  logic [AW-1:0] r_wp, r_rp;
  logic [AW:0]   r_cnt, w_cnt_nxt;
  logic          r_full, r_empty;
  logic          w_wr, w_rd;

  // Writes are refused while full even if a read frees a slot.
  assign w_wr      = i_wr & ~r_full;
  assign w_rd      = i_rd & ~r_empty;
  assign w_cnt_nxt = r_cnt + (AW+1)'(w_wr)
                   - (AW+1)'(w_rd);

  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n) begin
      r_wp    <= '0;
      r_rp    <= '0;
      r_cnt   <= '0;
      r_full  <= 1'b0;
      r_empty <= 1'b1;
    end else begin
      if (w_wr) r_wp <= r_wp + 1'b1;
      if (w_rd) r_rp <= r_rp + 1'b1;
      r_cnt   <= w_cnt_nxt;
      r_full  <= (w_cnt_nxt == (AW+1)'(DEPTH));
      r_empty <= (w_cnt_nxt == '0);
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_wr) r_mem[r_wp] <= i_wdata;
  end

  assign o_rdata = r_mem[r_rp];
  assign o_full  = r_full;
  assign o_empty = r_empty;
endmodule

// File: rtl/vpifo_sram_top.sv
// Virtualized PIFO: LEVEL lanes feed TREE_NUM sorted queues via one engine.
// Ports: per-lane i_push/i_pop/i_tree_id/i_push_data in; o_pop_data and
// o_task_fifo_full out; o_pop_valid only with VPIFO_POP_VALID_EN defined.
module vpifo_sram_top
  import vpifo_pkg::*;
#(
  parameter  int PTW       = 16,
  parameter  int MTW       = 0,
  parameter  int CTW       = 16,
  parameter  int LEVEL     = 5,
  parameter  int TREE_NUM  = 10,
  parameter  int FIFO_SIZE = 2097152,
  localparam int DW        = PTW + MTW,
  localparam int TIDW      = idw_f(TREE_NUM)
) (
  input  logic                           i_clk,
  input  logic                           i_arst_n,
  input  logic [LEVEL-1:0][TIDW-1:0]     i_tree_id,
  input  logic [LEVEL-1:0]               i_push,
  input  logic [LEVEL-1:0][DW-1:0]       i_push_data,
  input  logic [LEVEL-1:0]               i_pop,
`ifdef VPIFO_POP_VALID_EN
  output logic [LEVEL-1:0]               o_pop_valid,
`endif
  output logic [LEVEL-1:0][DW-1:0]       o_pop_data,
  output logic [LEVEL-1:0]               o_task_fifo_full
);
  localparam int CAP = cap_f(LEVEL);
  localparam int LW  = idw_f(LEVEL);

  typedef struct packed {
    op_e             op;
    logic [TIDW-1:0] tree_id;
    logic [DW-1:0]   data;
  } task_t;

  typedef logic [CAP-1:0][DW-1:0] row_t;
  localparam int TW = $bits(task_t);

  task_t [LEVEL-1:0] w_wtask, w_rtask;
  logic  [LEVEL-1:0] w_wr, w_rd, w_full, w_empty;

  always_comb begin
    for (int j = 0; j < LEVEL; j++) begin
      w_wtask[j].op      = i_push[j] ? OP_PUSH : OP_POP;
      w_wtask[j].tree_id = i_tree_id[j];
      w_wtask[j].data    = i_push[j] ? i_push_data[j] : '0;
      w_wr[j] = (i_push[j] | i_pop[j]) & ~w_full[j]
              & ({1'b0, i_tree_id[j]} < (TIDW+1)'(TREE_NUM));
    end
  end

  for (genvar j = 0; j < LEVEL; j++) begin : g_lane
    vpifo_task_fifo #(
      .DW    (TW),
      .DEPTH (FIFO_SIZE)
    ) u_fifo (
      .i_clk    (i_clk),
      .i_arst_n (i_arst_n),
      .i_wr     (w_wr[j]),
      .i_wdata  (w_wtask[j]),
      .i_rd     (w_rd[j]),
      .o_rdata  (w_rtask[j]),
      .o_full   (w_full[j]),
      .o_empty  (w_empty[j])
    );
  end

  logic [LW-1:0] r_rr, w_sel, w_rr_nxt;
  logic          w_any;

  // Scan downward so the lane closest after r_rr wins.
  always_comb begin
    int idx;
    idx   = 0;
    w_sel = '0;
    w_any = 1'b0;
    for (int i = LEVEL - 1; i >= 0; i--) begin
      idx = (int'(r_rr) + i) % LEVEL;
      if (!w_empty[idx]) begin
        w_sel = LW'(idx);
        w_any = 1'b1;
      end
    end
    w_rd = '0;
    if (w_any) w_rd[w_sel] = 1'b1;
    w_rr_nxt = (w_sel == LW'(LEVEL - 1)) ? '0
             : w_sel + 1'b1;
  end

  task_t                   r_task;
  logic                    r_tv;
  logic [LW-1:0]           r_lane;
  row_t                    r_mem [TREE_NUM];
  logic [CTW-1:0]          r_cnt [TREE_NUM];
  logic [LEVEL-1:0][DW-1:0] r_pop_data;

  logic [TIDW-1:0] w_tid;
  logic [CTW-1:0]  w_cnt;
  row_t            w_row, w_irow, w_prow, w_wrow;
  logic [CAP-1:0]  w_gt;
  logic            w_we;

  // Empty slots count as "greater" so the new entry lands at the tail
  // when nothing stored outranks it; equal keys stay ahead of it.
  always_comb begin
    w_tid = r_task.tree_id;
    w_cnt = r_cnt[w_tid];
    w_row = r_mem[w_tid];
    for (int k = 0; k < CAP; k++) begin
      w_gt[k] = (CTW'(k) >= w_cnt)
              || (w_row[k][DW-1 -: PTW]
                  > r_task.data[DW-1 -: PTW]);
    end
    w_irow    = w_row;
    w_irow[0] = w_gt[0] ? r_task.data : w_row[0];
    for (int k = 1; k < CAP; k++) begin
      unique case (1'b1)
        !w_gt[k]:   w_irow[k] = w_row[k];
        w_gt[k-1]:  w_irow[k] = w_row[k-1];
        default:    w_irow[k] = r_task.data;
      endcase
    end
    w_prow = w_row;
    for (int k = 0; k < CAP - 1; k++) begin
      w_prow[k] = w_row[k+1];
    end
    w_we = 1'b0;
    if (r_tv) begin
      unique case (r_task.op)
        OP_PUSH: w_we = (w_cnt != CTW'(CAP));
        OP_POP:  w_we = (w_cnt != '0);
        default: w_we = 1'b0;
      endcase
    end
    w_wrow = (r_task.op == OP_POP) ? w_prow : w_irow;
  end

  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n) begin
      r_tv       <= 1'b0;
      r_task     <= '0;
      r_lane     <= '0;
      r_rr       <= '0;
      r_pop_data <= '0;
      for (int t = 0; t < TREE_NUM; t++) r_cnt[t] <= '0;
    end else begin
      r_tv <= w_any;
      if (w_any) begin
        r_task <= w_rtask[w_sel];
        r_lane <= w_sel;
        r_rr   <= w_rr_nxt;
      end
      if (w_we) begin
        if (r_task.op == OP_PUSH) begin
          r_cnt[w_tid] <= w_cnt + 1'b1;
        end else begin
          r_cnt[w_tid]       <= w_cnt - 1'b1;
          r_pop_data[r_lane] <= w_row[0];
        end
      end
    end
  end

  // Storage is not reset; the per-tree counters define what is valid.
  always_ff @(posedge i_clk) begin
    if (w_we) r_mem[w_tid] <= w_wrow;
  end

`ifdef VPIFO_POP_VALID_EN
  logic [LEVEL-1:0] r_pop_valid;

  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n) begin
      r_pop_valid <= '0;
    end else begin
      r_pop_valid <= '0;
      if (w_we && r_task.op == OP_POP) r_pop_valid[r_lane] <= 1'b1;
    end
  end

  assign o_pop_valid = r_pop_valid;
`endif

  assign o_pop_data = r_pop_data;

  always_comb begin
    for (int j = 0; j < LEVEL; j++) o_task_fifo_full[j] = w_full[j];
  end
endmodule

// File: tb/tb_vpifo_sram_top.sv
// Randomized and directed bench for vpifo_sram_top against a queue model.
// Optional o_pop_valid is checked when VPIFO_POP_VALID_EN is defined.
module tb_vpifo_sram_top;
  import vpifo_pkg::*;

  localparam int PTW       = 16;
  localparam int MTW       = 4;
  localparam int CTW       = 8;
  localparam int LEVEL     = 5;
  localparam int TREE_NUM  = 10;
  localparam int FIFO_SIZE = 4;
  localparam int DW        = PTW + MTW;
  localparam int TIDW      = idw_f(TREE_NUM);
  localparam int CAP       = cap_f(LEVEL);

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic [LEVEL-1:0][TIDW-1:0] tid;
  logic [LEVEL-1:0]           push, pop;
  logic [LEVEL-1:0][DW-1:0]   pdata;
  logic [LEVEL-1:0][DW-1:0]   o_pd;
  logic [LEVEL-1:0]           o_full;
`ifdef VPIFO_POP_VALID_EN
  logic [LEVEL-1:0]           o_pv;
`endif

  vpifo_sram_top #(
    .PTW       (PTW),
    .MTW       (MTW),
    .CTW       (CTW),
    .LEVEL     (LEVEL),
    .TREE_NUM  (TREE_NUM),
    .FIFO_SIZE (FIFO_SIZE)
  ) dut (
    .i_clk            (clk),
    .i_arst_n         (rst_n),
    .i_tree_id        (tid),
    .i_push           (push),
    .i_push_data      (pdata),
    .i_pop            (pop),
`ifdef VPIFO_POP_VALID_EN
    .o_pop_valid      (o_pv),
`endif
    .o_pop_data       (o_pd),
    .o_task_fifo_full (o_full)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit            op;
    int            tree;
    logic [DW-1:0] data;
  } mtask_t;

  mtask_t           mq [LEVEL][$];
  logic [DW-1:0]    mt [TREE_NUM][$];
  logic [DW-1:0]    m_pd [LEVEL];
  logic [LEVEL-1:0] m_pv;
  logic [LEVEL-1:0] m_full;
  bit               m_busy;
  mtask_t           m_cur;
  int               m_lane;
  int               m_rr;
  int               checks   = 0;
  int               failures = 0;

  function automatic logic [DW-1:0] mk(input int p, input int m);
    return {PTW'(p), MTW'(m)};
  endfunction

  function automatic int prio(input logic [DW-1:0] d);
    return int'(d[DW-1 -: PTW]);
  endfunction

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      if (failures <= 30)
        $display("FAIL %s actual=%0h required=%0h t=%0t",
                 nm, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    for (int j = 0; j < LEVEL; j++) begin
      mq[j].delete();
      m_pd[j] = '0;
    end
    for (int t = 0; t < TREE_NUM; t++) mt[t].delete();
    m_pv   = '0;
    m_full = '0;
    m_busy = 1'b0;
    m_rr   = 0;
  endtask

  task automatic model_exec(input mtask_t tk, input int l);
    int p;
    if (tk.op == 1'b0) begin
      if (mt[tk.tree].size() < CAP) begin
        p = mt[tk.tree].size();
        for (int k = mt[tk.tree].size() - 1; k >= 0; k--)
          if (prio(mt[tk.tree][k]) > prio(tk.data)) p = k;
        mt[tk.tree].insert(p, tk.data);
      end
    end else if (mt[tk.tree].size() > 0) begin
      m_pd[l] = mt[tk.tree].pop_front();
      m_pv[l] = 1'b1;
    end
  endtask

  // One clock edge: run the task picked last edge, pick the next one
  // round-robin, then accept this edge's requests.
  task automatic model_step();
    int     pre [LEVEL];
    mtask_t tk;
    m_pv = '0;
    if (!rst_n) begin
      model_clear();
      return;
    end
    if (m_busy) model_exec(m_cur, m_lane);
    for (int j = 0; j < LEVEL; j++) pre[j] = mq[j].size();
    m_busy = 1'b0;
    for (int i = 0; i < LEVEL; i++) begin
      int l;
      l = (m_rr + i) % LEVEL;
      if (pre[l] > 0) begin
        m_cur  = mq[l].pop_front();
        m_lane = l;
        m_busy = 1'b1;
        m_rr   = (l + 1) % LEVEL;
        break;
      end
    end
    for (int j = 0; j < LEVEL; j++) begin
      if ((push[j] || pop[j]) && int'(tid[j]) < TREE_NUM
          && pre[j] < FIFO_SIZE) begin
        tk.op   = push[j] ? 1'b0 : 1'b1;
        tk.tree = int'(tid[j]);
        tk.data = push[j] ? pdata[j] : '0;
        mq[j].push_back(tk);
      end
    end
    for (int j = 0; j < LEVEL; j++)
      m_full[j] = (mq[j].size() == FIFO_SIZE);
  endtask

  function automatic bit m_idle();
    bit r;
    r = !m_busy;
    for (int j = 0; j < LEVEL; j++) if (mq[j].size() != 0) r = 1'b0;
    return r;
  endfunction

  function automatic bit m_all_empty();
    bit r;
    r = 1'b1;
    for (int t = 0; t < TREE_NUM; t++) if (mt[t].size() != 0) r = 1'b0;
    return r;
  endfunction

  task automatic compare();
    for (int j = 0; j < LEVEL; j++)
      chk($sformatf("pop_data[%0d]", j), 64'(o_pd[j]), 64'(m_pd[j]));
    chk("fifo_full", 64'(o_full), 64'(m_full));
`ifdef VPIFO_POP_VALID_EN
    chk("pop_valid", 64'(o_pv), 64'(m_pv));
`endif
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare();
  endtask

  task automatic idle();
    push  = '0;
    pop   = '0;
    tid   = '0;
    pdata = '0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    idle();
    while (!m_idle() && n < 200) begin
      cycle();
      n++;
    end
    chk("drain_bound", 64'(m_idle()), 64'(1));
  endtask

  task automatic flush();
    for (int r = 0; r < 140 && !m_all_empty(); r++) begin
      for (int j = 0; j < LEVEL; j++) begin
        pop[j] = 1'b1;
        tid[j] = TIDW'(j + 5 * (r % 2));
      end
      cycle();
      drain();
    end
    chk("flush_bound", 64'(m_all_empty()), 64'(1));
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    model_clear();
    cycle();
    rst_n = 1'b1;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int ord [3];
    idle();
    model_clear();
    cycle();
    cycle();
    for (int j = 0; j < LEVEL; j++)
      chk("reset_pd", 64'(o_pd[j]), 64'(0));
    chk("reset_full", 64'(o_full), 64'(0));
    rst_n = 1'b1;

    // Empty tree pop leaves data at its reset value.
    pop[2] = 1'b1;
    tid[2] = TIDW'(7);
    cycle();
    drain();
    chk("empty_pop", 64'(o_pd[2]), 64'(0));

    // Ordering on one tree.
    ord[0] = 30; ord[1] = 10; ord[2] = 20;
    for (int k = 0; k < 3; k++) begin
      push[0]  = 1'b1;
      tid[0]   = TIDW'(3);
      pdata[0] = mk(ord[k], k + 1);
      cycle();
    end
    drain();
    for (int k = 0; k < 3; k++) begin
      pop[0] = 1'b1;
      tid[0] = TIDW'(3);
      cycle();
      drain();
      chk("order", 64'(o_pd[0][DW-1 -: PTW]), 64'(10 * (k + 1)));
    end

    // Fill every tree to capacity, then pop them back in order.
    for (int g = 0; g < 2; g++) begin
      for (int i = 0; i < CAP; i++) begin
        for (int j = 0; j < LEVEL; j++) begin
          push[j]  = 1'b1;
          tid[j]   = TIDW'(j + 5 * g);
          pdata[j] = mk(4096 * (j + 5 * g) + i, j);
        end
        cycle();
        drain();
      end
    end
    for (int g = 0; g < 2; g++) begin
      for (int i = 0; i < CAP; i++) begin
        for (int j = 0; j < LEVEL; j++) begin
          pop[j] = 1'b1;
          tid[j] = TIDW'(j + 5 * g);
        end
        cycle();
        drain();
        for (int j = 0; j < LEVEL; j++)
          chk("fill", 64'(o_pd[j][DW-1 -: PTW]),
              64'(4096 * (j + 5 * g) + i));
      end
    end

    // Overflow: the 63rd push is discarded.
    for (int i = 0; i <= CAP; i++) begin
      push[0]  = 1'b1;
      tid[0]   = '0;
      pdata[0] = mk(i, 3);
      cycle();
    end
    drain();
    for (int i = 0; i <= CAP; i++) begin
      pop[0] = 1'b1;
      tid[0] = '0;
      cycle();
      drain();
      chk("overflow", 64'(o_pd[0][DW-1 -: PTW]),
          64'((i < CAP) ? i : CAP - 1));
    end

    // Backpressure from a clean state.
    pulse_reset();
    for (int k = 0; k < 8; k++) begin
      for (int j = 0; j < LEVEL; j++) begin
        push[j]  = 1'b1;
        tid[j]   = TIDW'(j);
        pdata[j] = mk(100 * (8 - k) + j, k);
      end
      cycle();
      if (k == 3) chk("bp_full", 64'(o_full), 64'(5'b11000));
    end
    drain();
    flush();

    // Random traffic with ties, drops and invalid tree ids.
    for (int c = 0; c < 400; c++) begin
      for (int j = 0; j < LEVEL; j++) begin
        int r;
        r        = $urandom_range(0, 9);
        push[j]  = (r < 4) || (r == 7);
        pop[j]   = (r >= 4) && (r < 8);
        tid[j]   = TIDW'($urandom_range(0, 15));
        pdata[j] = mk($urandom_range(0, 7), $urandom_range(0, 15));
      end
      cycle();
    end
    drain();
    flush();

    // Reset in the middle of a backlog.
    for (int c = 0; c < 10; c++) begin
      for (int j = 0; j < LEVEL; j++) begin
        push[j]  = 1'b1;
        tid[j]   = TIDW'($urandom_range(0, TREE_NUM - 1));
        pdata[j] = mk($urandom_range(1, 999), c);
      end
      cycle();
    end
    #2;
    rst_n = 1'b0;
    model_clear();
    #1;
    compare();
    for (int j = 0; j < LEVEL; j++)
      chk("midrst_pd", 64'(o_pd[j]), 64'(0));
    chk("midrst_full", 64'(o_full), 64'(0));
    idle();
    cycle();
    cycle();
    rst_n = 1'b1;
    for (int r = 0; r < 2; r++) begin
      for (int j = 0; j < LEVEL; j++) begin
        pop[j] = 1'b1;
        tid[j] = TIDW'(j + 5 * r);
      end
      cycle();
      drain();
    end
    for (int j = 0; j < LEVEL; j++)
      chk("post_rst_pd", 64'(o_pd[j]), 64'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
